lcd_nibble_rx: RTL and testbench
================================

Name: lcd_nibble_rx

Overview:
- Display-side receiver for the 4-bit HD44780-style LCD bus driven by our LCD writer blocks (e, sf_e, rs, rw, d/c/b/a).
- Samples nibbles on the falling edge of e and tracks the power-on 8-bit/4-bit init handshake.
- Reassembles nibble pairs into bytes, decodes instructions, and maintains a small DDRAM plus display status.
- Used as an on-chip loopback checker and simulation target for display drivers.

Parameters:
- DEPTH, 32: DDRAM entries; address wraps modulo DEPTH; power of 2.
- SYNC_STAGES, 2: synchronizer flops on all bus inputs; minimum 1.
- CLEAR_CYCLES, 82000: busy duration after Clear Display, in clk cycles.
- CMD_CYCLES, 2000: busy duration after any other completed byte, in clk cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_e  in  1  enable strobe; nibble captured on its falling edge
- lcd_sf_e  in  1  1 = LCD access; strobes with 0 are ignored
- lcd_rs  in  1  register select (0 instruction, 1 data)
- lcd_rw  in  1  1 = read; read strobes are ignored
- lcd_db  in  4  {d,c,b,a}, d = bit 3
- byte_valid  out  1  one-cycle pulse when a byte completes
- byte_data  out  8  completed byte
- byte_rs  out  1  rs of the completed byte
- mode4  out  1  4-bit mode reached
- disp_on  out  1  display D bit
- entry_inc  out  1  entry-mode I/D bit
- cur_addr  out  log2(DEPTH)  DDRAM address counter
- rd_addr  in  log2(DEPTH)  debug read address
- rd_data  out  8  ddram[rd_addr], registered, 1-cycle latency
- busy  out  1  models the busy flag
- proto_err  out  1  sticky: rs mismatch between the two halves of a byte
- overrun  out  1  sticky: strobe accepted while busy

Behaviour:
- Reset (rst_n low, async): all outputs 0 except entry_inc=1; FSM=INIT; DDRAM filled with 8'h20. The DDRAM fill may take DEPTH cycles after reset release; busy=1 during the fill.
- Strobe: all inputs pass through SYNC_STAGES flops. A strobe is synced e going 1 to 0 while synced sf_e=1 and rw=0. Bus values are those of the synced sample preceding the edge.
- FSM INIT:
  - Each strobe with rs=0 is a single 8-bit-mode nibble.
  - Nibble 4'h2 sets mode4=1 and moves to HI.
  - Nibble 4'h3 stays in INIT.
  - Any other nibble, or rs=1, is ignored.
- FSM HI: latch the nibble as byte[7:4] and its rs, then go to LO.
- FSM LO:
  - Nibble goes to byte[3:0].
  - If rs equals the latched rs: byte complete, byte_valid pulses the next cycle (SYNC_STAGES+1 clk after e is sampled low), return to HI.
  - If rs differs: set proto_err, discard the byte, return to HI. The lower nibble is not reused.
- Decode on byte complete, instruction bytes (rs=0), highest set bit wins:
  - 8'h01 clear: DDRAM fill 8'h20, cur_addr=0, entry_inc=1.
  - 8'h02/03 home: cur_addr=0.
  - 8'h04-07 entry mode: entry_inc=bit1.
  - 8'h08-0F display control: disp_on=bit2.
  - 8'h20-3F function set: bit4=1 returns to INIT with mode4=0.
  - 8'h80-FF set address: cur_addr = byte[log2(DEPTH)-1:0].
  - Others: no effect beyond byte_valid.
- Decode on byte complete, data bytes (rs=1): ddram[cur_addr]=byte. cur_addr then increments or decrements per entry_inc, wrapping modulo DEPTH in both directions (0 minus 1 = DEPTH-1).
- Busy:
  - busy=1 for CLEAR_CYCLES after a clear, and CMD_CYCLES after any other completed byte.
  - A strobe while busy is still processed, and sets overrun.
- Simultaneous events: a strobe during the clear fill is processed after the fill completes. A single-entry strobe hold register is used; a second strobe during the fill is dropped, and sets overrun when LCD_BUSY_MODEL_EN is defined.
- Reset mid-byte: discards the half byte and returns to INIT.

Optional Feature:
- Macro: LCD_BUSY_MODEL_EN.
- Defined: busy counters and overrun behave as above.
- Undefined: busy is high only during the DDRAM fill, overrun is tied 0, and no busy counters are synthesized.

Decomposition:
- Package lcd_pkg holds:
  - FSM state enum {INIT, HI, LO}.
  - Instruction constants CMD_CLEAR=8'h01, CMD_ENTRY=8'h04, CMD_DISP=8'h08, CMD_FSET=8'h20, CMD_SETDD=8'h80.
  - Fill character 8'h20.
- Sub-module lcd_strobe_sync: synchronizer plus falling-edge detector, output strobe and the aligned {rs, rw, db}.

Test Plan:
- Init sequence: nibbles 3,3,3,2 then bytes 28,06,0C,01 (rs=0) -> mode4=1, entry_inc=1, disp_on=1, cur_addr=0, all rd_data=8'h20.
- After init, nibbles 3,0 with rs=1 -> byte_valid with byte_data=8'h30, byte_rs=1; ddram[0]=8'h30; cur_addr=1.
- Byte 8'h04, then 8'h80, then data 8'h41 -> ddram[0]=8'h41 and cur_addr=DEPTH-1 (decrement wrap).
- Upper nibble with rs=1, lower nibble with rs=0 -> proto_err=1, no byte_valid; the next clean byte decodes correctly.
- Two data bytes with no gap after 8'h01 (LCD_BUSY_MODEL_EN defined) -> overrun=1 and both bytes written. Same stimulus with the macro undefined -> overrun=0.
- Pull rst_n low between the two nibbles of a byte -> INIT, mode4=0, no byte_valid; the init sequence works again after release.

Source files
------------

// File: rtl/lcd_nibble_rx_pkg.sv
// Shared types and constants for the LCD nibble receiver: FSM states,
// instruction opcodes, the DDRAM fill character, and the instruction
// classifier used by the byte decoder.
package lcd_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_HOME  = 3'd2,
    OP_ENTRY = 3'd3,
    OP_DISP  = 3'd4,
    OP_FSET  = 3'd5,
    OP_SETDD = 3'd6
  } op_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_FSET  = 8'h20;
  localparam logic [7:0] CMD_SETDD = 8'h80;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  // The highest set bit of an instruction byte selects the command.
  // Bits 6 (CGRAM address) and 4 (cursor/display shift) are not modelled.
  function automatic op_e decode_cmd(input logic [7:0] b);
    op_e op;
    if ((b & CMD_SETDD) != 8'h00)      op = OP_SETDD;
    else if (b[6])                     op = OP_NONE;
    else if ((b & CMD_FSET) != 8'h00)  op = OP_FSET;
    else if (b[4])                     op = OP_NONE;
    else if ((b & CMD_DISP) != 8'h00)  op = OP_DISP;
    else if ((b & CMD_ENTRY) != 8'h00) op = OP_ENTRY;
    else if (b[1])                     op = OP_HOME;
    else if ((b & CMD_CLEAR) != 8'h00) op = OP_CLEAR;
    else                               op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Bus synchronizer and falling-edge detector for the LCD strobe.
// All bus inputs go through the same SYNC_STAGES flop chain so they stay
// aligned; the reported rs/rw/db are those of the last sample with e high.
module lcd_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_e,
  input  logic       lcd_sf_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_db,
  output logic       strobe_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [3:0] db_o
);

  localparam int NS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

  // Bit layout of a bus sample: {e, sf_e, rs, rw, db[3:0]}
  logic [7:0] sync_q [NS];
  logic [7:0] prev_q;

  // Synchronizer chain plus one extra sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_sf_e, lcd_rs, lcd_rw, lcd_db};
      for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[NS-1];
    end
  end

  assign strobe_o = prev_q[7] & ~sync_q[NS-1][7] & prev_q[6];
  assign rs_o     = prev_q[5];
  assign rw_o     = prev_q[4];
  assign db_o     = prev_q[3:0];

endmodule

// File: rtl/lcd_nibble_rx.sv
// Display-side receiver for the 4-bit HD44780-style LCD bus.
// Tracks the 8-bit/4-bit init handshake, pairs nibbles into bytes,
// decodes instructions and keeps a small DDRAM plus display status.
// Optional feature macro: LCD_BUSY_MODEL_EN enables the busy-time counters
// and the overrun flag; without it busy only covers the DDRAM fill.
module lcd_nibble_rx
  import lcd_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 82000,
  parameter int CMD_CYCLES   = 2000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lcd_e,
  input  logic                     lcd_sf_e,
  input  logic                     lcd_rs,
  input  logic                     lcd_rw,
  input  logic [3:0]               lcd_db,
  output logic                     byte_valid,
  output logic [7:0]               byte_data,
  output logic                     byte_rs,
  output logic                     mode4,
  output logic                     disp_on,
  output logic                     entry_inc,
  output logic [$clog2(DEPTH)-1:0] cur_addr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic                     busy,
  output logic                     proto_err,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic       stb, s_rs, s_rw, acc;
  logic [3:0] s_db;

  state_e     state_q, state_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       hi_rs_q, hi_rs_d;
  logic       mode4_q, mode4_d;
  logic       disp_on_q, disp_on_d;
  logic       entry_inc_q, entry_inc_d;
  logic       proto_err_q, proto_err_d;
  logic       byte_valid_q;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_rs_q, byte_rs_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;

  logic          started_q, fill_q, fill_go;
  logic [AW-1:0] fill_addr_q;

  logic       hold_vld_q, hold_rs_q;
  logic [3:0] hold_db_q;

  logic       proc_vld, proc_rs;
  logic [3:0] proc_db;
  logic       cmplt, clear_cmd, data_wr;
  logic [7:0] byte_c;

  logic       busy_w, overrun_w;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  lcd_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_e    (lcd_e),
    .lcd_sf_e (lcd_sf_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_db   (lcd_db),
    .strobe_o (stb),
    .rs_o     (s_rs),
    .rw_o     (s_rw),
    .db_o     (s_db)
  );

  // Read strobes carry no data for the display and are dropped here
  assign acc = stb & ~s_rw;

  // Pick the strobe to act on: nothing during a fill, the held one first after
  always_comb begin
    proc_vld = 1'b0;
    proc_rs  = hold_rs_q;
    proc_db  = hold_db_q;
    if (!fill_q) begin
      if (hold_vld_q) begin
        proc_vld = 1'b1;
      end else if (acc) begin
        proc_vld = 1'b1;
        proc_rs  = s_rs;
        proc_db  = s_db;
      end
    end
  end

  // Single-entry hold for strobes arriving while DDRAM is being filled;
  // a strobe that finds the hold full during a fill is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q <= 1'b0;
      hold_rs_q  <= 1'b0;
      hold_db_q  <= '0;
    end else if (fill_q) begin
      if (acc && !hold_vld_q) begin
        hold_vld_q <= 1'b1;
        hold_rs_q  <= s_rs;
        hold_db_q  <= s_db;
      end
    end else if (hold_vld_q) begin
      hold_vld_q <= acc;
      if (acc) begin
        hold_rs_q <= s_rs;
        hold_db_q <= s_db;
      end
    end
  end

  // DDRAM fill sequencer: runs once after reset and after every Clear Display
  assign fill_go = ~started_q | clear_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q   <= 1'b0;
      fill_q      <= 1'b0;
      fill_addr_q <= '0;
    end else begin
      started_q <= 1'b1;
      if (fill_go) begin
        fill_q      <= 1'b1;
        fill_addr_q <= '0;
      end else if (fill_q) begin
        fill_addr_q <= fill_addr_q + 1'b1;
        if (fill_addr_q == AW'(DEPTH - 1)) fill_q <= 1'b0;
      end
    end
  end

  // DDRAM write port shared by the fill sequencer and data bytes
  always_ff @(posedge clk) begin
    if (fill_q) begin
      mem_q[fill_addr_q] <= FILL_CHAR;
    end else if (data_wr) begin
      mem_q[cur_addr_q] <= byte_c;
    end
  end

  // Registered debug read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem_q[rd_addr];
  end

  // Receiver FSM and display status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      hi_nib_q     <= '0;
      hi_rs_q      <= 1'b0;
      mode4_q      <= 1'b0;
      disp_on_q    <= 1'b0;
      entry_inc_q  <= 1'b1;
      proto_err_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_rs_q    <= 1'b0;
      cur_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      hi_nib_q     <= hi_nib_d;
      hi_rs_q      <= hi_rs_d;
      mode4_q      <= mode4_d;
      disp_on_q    <= disp_on_d;
      entry_inc_q  <= entry_inc_d;
      proto_err_q  <= proto_err_d;
      byte_valid_q <= cmplt;
      byte_data_q  <= byte_data_d;
      byte_rs_q    <= byte_rs_d;
      cur_addr_q   <= cur_addr_d;
    end
  end

  // Next-state logic: init handshake, nibble pairing and byte decode
  always_comb begin
    state_d     = state_q;
    hi_nib_d    = hi_nib_q;
    hi_rs_d     = hi_rs_q;
    mode4_d     = mode4_q;
    disp_on_d   = disp_on_q;
    entry_inc_d = entry_inc_q;
    proto_err_d = proto_err_q;
    byte_data_d = byte_data_q;
    byte_rs_d   = byte_rs_q;
    cur_addr_d  = cur_addr_q;
    cmplt       = 1'b0;
    clear_cmd   = 1'b0;
    data_wr     = 1'b0;
    byte_c      = {hi_nib_q, proc_db};

    case (state_q)
      INIT: begin
        // 8-bit-mode nibbles: 3 keeps waiting, 2 switches to 4-bit mode
        if (proc_vld && !proc_rs && (proc_db == 4'h2)) begin
          mode4_d = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        if (proc_vld) begin
          hi_nib_d = proc_db;
          hi_rs_d  = proc_rs;
          state_d  = LO;
        end
      end
      LO: begin
        if (proc_vld) begin
          state_d = HI;
          if (proc_rs != hi_rs_q) begin
            // Mismatched halves: drop the whole byte, realign on the next nibble
            proto_err_d = 1'b1;
          end else begin
            cmplt       = 1'b1;
            byte_data_d = byte_c;
            byte_rs_d   = proc_rs;
            if (hi_rs_q) begin
              data_wr    = 1'b1;
              cur_addr_d = entry_inc_q ? cur_addr_q + 1'b1 : cur_addr_q - 1'b1;
            end else begin
              case (decode_cmd(byte_c))
                OP_CLEAR: begin
                  clear_cmd   = 1'b1;
                  cur_addr_d  = '0;
                  entry_inc_d = 1'b1;
                end
                OP_HOME:  cur_addr_d  = '0;
                OP_ENTRY: entry_inc_d = byte_c[1];
                OP_DISP:  disp_on_d   = byte_c[2];
                OP_FSET: begin
                  if (byte_c[4]) begin
                    mode4_d = 1'b0;
                    state_d = INIT;
                  end
                end
                OP_SETDD: cur_addr_d = byte_c[AW-1:0];
                default: ;
              endcase
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

`ifdef LCD_BUSY_MODEL_EN
  localparam int BMAX = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CW   = $clog2(BMAX + 1);

  logic [CW-1:0] busy_cnt_q;
  logic          overrun_q;

  // Busy-time model and sticky overrun for strobes that arrive while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (cmplt) begin
        busy_cnt_q <= clear_cmd ? CW'(CLEAR_CYCLES) : CW'(CMD_CYCLES);
      end else if (busy_cnt_q != '0) begin
        busy_cnt_q <= busy_cnt_q - 1'b1;
      end
      if (acc && busy_w) overrun_q <= 1'b1;
    end
  end

  assign busy_w    = fill_q | (busy_cnt_q != '0);
  assign overrun_w = overrun_q;
`else
  assign busy_w    = fill_q;
  assign overrun_w = 1'b0;
`endif

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_rs    = byte_rs_q;
  assign mode4      = mode4_q;
  assign disp_on    = disp_on_q;
  assign entry_inc  = entry_inc_q;
  assign cur_addr   = cur_addr_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_w;
  assign proto_err  = proto_err_q;
  assign overrun    = overrun_w;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Testbench for lcd_nibble_rx: drives the 4-bit LCD bus like a display
// writer and checks the receiver against a byte-level display model.
module tb_lcd_nibble_rx;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lcd_e = 1'b0;
  logic          lcd_sf_e = 1'b0;
  logic          lcd_rs = 1'b0;
  logic          lcd_rw = 1'b0;
  logic [3:0]    lcd_db = 4'h0;
  logic [AW-1:0] rd_addr = '0;

  logic          byte_valid, byte_rs, mode4, disp_on, entry_inc;
  logic [7:0]    byte_data, rd_data;
  logic [AW-1:0] cur_addr;
  logic          busy, proto_err, overrun;

  lcd_nibble_rx #(
    .DEPTH        (DEPTH),
    .SYNC_STAGES  (2),
    .CLEAR_CYCLES (300),
    .CMD_CYCLES   (25)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_e      (lcd_e),
    .lcd_sf_e   (lcd_sf_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_db     (lcd_db),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_rs    (byte_rs),
    .mode4      (mode4),
    .disp_on    (disp_on),
    .entry_inc  (entry_inc),
    .cur_addr   (cur_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .proto_err  (proto_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LCD_BUSY_MODEL_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  // Every completed byte reported by the DUT, as {rs, data}
  logic [8:0] got_q[$];
  always @(negedge clk) if (byte_valid === 1'b1) got_q.push_back({byte_rs, byte_data});

  // Display model
  logic [7:0] m_mem [DEPTH];
  int m_addr, m_inc, m_disp, m_mode4, m_proto;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
    m_addr = 0; m_inc = 1; m_disp = 0; m_mode4 = 0; m_proto = 0;
  endtask

  task automatic model_byte(input logic rs, input logic [7:0] b);
    int v;
    v = int'(b);
    if (rs) begin
      m_mem[m_addr] = b;
      m_addr = (m_inc != 0) ? (m_addr + 1) % DEPTH : (m_addr + DEPTH - 1) % DEPTH;
    end else if (v >= 128) m_addr = v % DEPTH;
    else if (v >= 64) begin end
    else if (v >= 32) begin if ((v / 16) % 2 == 1) m_mode4 = 0; end
    else if (v >= 16) begin end
    else if (v >= 8) m_disp = (v / 4) % 2;
    else if (v >= 4) m_inc = (v / 2) % 2;
    else if (v >= 2) m_addr = 0;
    else if (v == 1) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
      m_addr = 0; m_inc = 1;
    end
  endtask

  task automatic nib_raw(input logic sf, input logic rw, input logic rs, input logic [3:0] d);
    @(negedge clk);
    lcd_sf_e = sf; lcd_rw = rw; lcd_rs = rs; lcd_db = d;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
    lcd_sf_e = 1'b0;
  endtask

  task automatic nib(input logic rs, input logic [3:0] d);
    nib_raw(1'b1, 1'b0, rs, d);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    nib(rs, b[7:4]);
    nib(rs, b[3:0]);
    model_byte(rs, b);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy=%b still set after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = AW'(a);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic run_init();
    nib(1'b0, 4'h3); nib(1'b0, 4'h3); nib(1'b0, 4'h3); nib(1'b0, 4'h2);
    m_mode4 = 1;
    wait_idle(); send_byte(1'b0, 8'h28);
    wait_idle(); send_byte(1'b0, 8'h06);
    wait_idle(); send_byte(1'b0, 8'h0C);
    wait_idle(); send_byte(1'b0, 8'h01);
    wait_idle();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    model_reset();
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({byte_valid, byte_data, byte_rs, mode4, disp_on, entry_inc, cur_addr,
         rd_data, busy, proto_err, overrun} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,
                                                 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: vld=%b data=%h rs=%b m4=%b don=%b inc=%b addr=%0d rd=%h busy=%b perr=%b ovr=%b, required all 0 except inc=1",
               byte_valid, byte_data, byte_rs, mode4, disp_on, entry_inc, cur_addr, rd_data, busy, proto_err, overrun);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_fill_busy: busy=%b required 1", busy); end
    wait_idle();
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, v);
      n_cmp++;
      if (v !== 8'h20) begin n_bad++; $display("FAIL reset_fill mem[%0d]: got %h required 20", i, v); end
    end
  endtask

  task automatic test_init();
    logic [7:0] v;
    int n0;
    n0 = got_q.size();
    run_init();
    n_cmp++;
    if (got_q.size() !== n0 + 4) begin
      n_bad++; $display("FAIL init_bytes: %0d bytes seen, required %0d", got_q.size() - n0, 4);
    end else if ({got_q[n0], got_q[n0+1], got_q[n0+2], got_q[n0+3]} !== {9'h028, 9'h006, 9'h00C, 9'h001}) begin
      n_bad++; $display("FAIL init_bytes: got %h %h %h %h required 028 006 00c 001",
                        got_q[n0], got_q[n0+1], got_q[n0+2], got_q[n0+3]);
    end
    n_cmp++;
    if ({mode4, entry_inc, disp_on, cur_addr} !== {m_mode4[0], m_inc[0], m_disp[0], AW'(m_addr)}) begin
      n_bad++; $display("FAIL init_status: m4=%b inc=%b don=%b addr=%0d required %0d %0d %0d %0d",
                        mode4, entry_inc, disp_on, cur_addr, m_mode4, m_inc, m_disp, m_addr);
    end
    for (int i = 0; i < DEPTH; i += 7) begin
      rd(i, v);
      n_cmp++;
      if (v !== m_mem[i]) begin n_bad++; $display("FAIL init_mem[%0d]: got %h required %h", i, v, m_mem[i]); end
    end
  endtask

  task automatic test_data_first();
    logic [7:0] v;
    int n0;
    n0 = got_q.size();
    nib(1'b1, 4'h3); nib(1'b1, 4'h0);
    model_byte(1'b1, 8'h30);
    n_cmp++;
    if (got_q.size() !== n0 + 1 || got_q[$] !== 9'h130) begin
      n_bad++; $display("FAIL data_30 byte: count=%0d last=%h required count=%0d last=130", got_q.size() - n0, got_q[$], 1);
    end
    rd(0, v);
    n_cmp++;
    if (v !== 8'h30 || cur_addr !== AW'(m_addr)) begin
      n_bad++; $display("FAIL data_30 mem/addr: mem0=%h addr=%0d required 30 / %0d", v, cur_addr, m_addr);
    end
    wait_idle();
  endtask

  task automatic test_dec_wrap();
    logic [7:0] v;
    send_byte(1'b0, 8'h04); wait_idle();
    send_byte(1'b0, 8'h80); wait_idle();
    send_byte(1'b1, 8'h41); wait_idle();
    rd(0, v);
    n_cmp++;
    if (v !== 8'h41) begin n_bad++; $display("FAIL dec_wrap mem0: got %h required 41", v); end
    n_cmp++;
    if (cur_addr !== AW'(DEPTH - 1) || entry_inc !== 1'b0) begin
      n_bad++; $display("FAIL dec_wrap addr: addr=%0d inc=%b required %0d / 0", cur_addr, entry_inc, DEPTH - 1);
    end
  endtask

  task automatic test_proto_err();
    logic [7:0] v;
    int n0, a0;
    n0 = got_q.size();
    nib(1'b1, 4'h4); nib(1'b0, 4'h1);
    m_proto = 1;
    n_cmp++;
    if (proto_err !== 1'b1 || got_q.size() !== n0) begin
      n_bad++; $display("FAIL proto_err: perr=%b bytes=%0d required 1 / 0", proto_err, got_q.size() - n0);
    end
    a0 = m_addr;
    send_byte(1'b1, 8'h5A); wait_idle();
    rd(a0, v);
    n_cmp++;
    if (got_q.size() !== n0 + 1 || got_q[$] !== 9'h15A || v !== 8'h5A || cur_addr !== AW'(m_addr)) begin
      n_bad++; $display("FAIL proto_recover: last=%h mem=%h addr=%0d required 15a / 5a / %0d", got_q[$], v, cur_addr, m_addr);
    end
  endtask

  task automatic test_ignored();
    int n0;
    n0 = got_q.size();
    nib_raw(1'b0, 1'b0, 1'b1, 4'hF);
    nib_raw(1'b1, 1'b1, 1'b1, 4'hE);
    send_byte(1'b1, 8'h6B); wait_idle();
    n_cmp++;
    if (got_q.size() !== n0 + 1 || got_q[$] !== 9'h16B) begin
      n_bad++; $display("FAIL ignored_strobes: bytes=%0d last=%h required 1 / 16b", got_q.size() - n0, got_q[$]);
    end
  endtask

  task automatic test_random();
    logic [7:0] b, v;
    logic rs;
    int n0, r;
    for (int it = 0; it < 50; it++) begin
      r = $urandom_range(0, 9);
      rs = 1'b0;
      case (r)
        0, 1, 2, 3, 4: begin rs = 1'b1; b = 8'($urandom); end
        5: b = 8'h80 | 8'($urandom_range(0, 127));
        6: b = 8'h04 | 8'($urandom_range(0, 3));
        7: b = 8'h08 | 8'($urandom_range(0, 7));
        8: begin
          case ($urandom_range(0, 4))
            0: b = 8'h02 | 8'($urandom_range(0, 1));
            1: b = 8'h10 | 8'($urandom_range(0, 15));
            2: b = 8'h40 | 8'($urandom_range(0, 63));
            3: b = 8'h20 | 8'($urandom_range(0, 15));
            default: b = 8'h00;
          endcase
        end
        default: begin
          if ($urandom_range(0, 2) == 0) b = 8'h01;
          else begin rs = 1'b1; b = 8'($urandom); end
        end
      endcase
      n0 = got_q.size();
      wait_idle();
      send_byte(rs, b);
      n_cmp++;
      if (got_q.size() !== n0 + 1 || got_q[$] !== {rs, b}) begin
        n_bad++; $display("FAIL rand_byte[%0d]: bytes=%0d last=%h required 1 / %h", it, got_q.size() - n0, got_q[$], {rs, b});
      end
    end
    wait_idle();
    n_cmp++;
    if ({mode4, entry_inc, disp_on, cur_addr} !== {m_mode4[0], m_inc[0], m_disp[0], AW'(m_addr)}) begin
      n_bad++; $display("FAIL rand_status: m4=%b inc=%b don=%b addr=%0d required %0d %0d %0d %0d",
                        mode4, entry_inc, disp_on, cur_addr, m_mode4, m_inc, m_disp, m_addr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, v);
      n_cmp++;
      if (v !== m_mem[i]) begin n_bad++; $display("FAIL rand_mem[%0d]: got %h required %h", i, v, m_mem[i]); end
    end
  endtask

  task automatic test_fset();
    int n0;
    n0 = got_q.size();
    wait_idle();
    send_byte(1'b0, 8'h30);
    n_cmp++;
    if (mode4 !== 1'b0 || got_q.size() !== n0 + 1) begin
      n_bad++; $display("FAIL fset_8bit: m4=%b bytes=%0d required 0 / 1", mode4, got_q.size() - n0);
    end
    wait_idle();
    nib(1'b0, 4'h3); nib(1'b0, 4'h2);
    m_mode4 = 1;
    wait_idle();
    send_byte(1'b0, 8'h0C); wait_idle();
    n_cmp++;
    if (mode4 !== 1'b1 || disp_on !== 1'b1 || got_q[$] !== 9'h00C) begin
      n_bad++; $display("FAIL fset_reinit: m4=%b don=%b last=%h required 1 / 1 / 00c", mode4, disp_on, got_q[$]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v0, v1;
    int n0;
    wait_idle();
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_pre: got %b required 0", overrun); end
    send_byte(1'b0, 8'h01);
    repeat (DEPTH + 10) @(negedge clk);
    n0 = got_q.size();
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h3C);
    n_cmp++;
    if (overrun !== OVR_EXP) begin n_bad++; $display("FAIL overrun_b2b: got %b required %b", overrun, OVR_EXP); end
    wait_idle();
    rd(0, v0); rd(1, v1);
    n_cmp++;
    if (got_q.size() !== n0 + 2 || v0 !== 8'hA5 || v1 !== 8'h3C || cur_addr !== AW'(m_addr)) begin
      n_bad++; $display("FAIL b2b_writes: bytes=%0d mem0=%h mem1=%h addr=%0d required 2 / a5 / 3c / %0d",
                        got_q.size() - n0, v0, v1, cur_addr, m_addr);
    end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] v;
    int n0;
    n0 = got_q.size();
    nib(1'b1, 4'h7);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mode4 !== 1'b0 || got_q.size() !== n0 || proto_err !== 1'b0 || overrun !== 1'b0) begin
      n_bad++; $display("FAIL midbyte_reset: m4=%b bytes=%0d perr=%b ovr=%b required 0 / 0 / 0 / 0",
                        mode4, got_q.size() - n0, proto_err, overrun);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    wait_idle();
    nib(1'b1, 4'h1);
    n0 = got_q.size();
    run_init();
    n_cmp++;
    if (got_q.size() !== n0 + 4 || mode4 !== 1'b1 || disp_on !== 1'b1) begin
      n_bad++; $display("FAIL midbyte_reinit: bytes=%0d m4=%b don=%b required 4 / 1 / 1", got_q.size() - n0, mode4, disp_on);
    end
    send_byte(1'b1, 8'h55); wait_idle();
    rd(0, v);
    n_cmp++;
    if (v !== 8'h55 || got_q[$] !== 9'h155 || cur_addr !== AW'(m_addr)) begin
      n_bad++; $display("FAIL midbyte_data: mem0=%h last=%h addr=%0d required 55 / 155 / %0d", v, got_q[$], cur_addr, m_addr);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_first();
    test_dec_wrap();
    test_proto_err();
    test_ignored();
    test_random();
    test_fset();
    test_back_to_back();
    test_reset_midbyte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
